spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_master_ctrl_clkgen.sv | 42 ++++
 rtl/spi_master_ctrl.sv | 171 +++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI register-access master
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RW,
        ST_WDATA,
        ST_TURN,
        ST_RDATA,
        ST_GAP
    } spi_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int DEF_SCLK_HALF  = 4;
    localparam int DEF_TURNAROUND = 5;
    localparam int DEF_CS_IDLE    = 2;

    localparam int ADDR_BITS = 7;
    localparam int DATA_BITS = 8;
    localparam int TX_BITS   = ADDR_BITS + 1 + DATA_BITS;

endpackage

// File: rtl/spi_master_ctrl_clkgen.sv
// rtl/spi_master_ctrl_clkgen.sv - sclk divider with rise strobe and bit-period-end strobe
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int SCLK_HALF = DEF_SCLK_HALF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(2 * SCLK_HALF);
    localparam logic [CW-1:0] RISE_AT = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] FALL_AT = CW'(2 * SCLK_HALF - 1);

    logic [CW-1:0] r_cnt;
    logic          r_sclk;

    // Each bit period starts low; disabling parks the divider at the period start.
    always_ff @(posedge clk) begin
        if (!rst_n || !i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (r_cnt == FALL_AT) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == RISE_AT) begin
                r_sclk <= 1'b1;
            end
        end
    end

    assign o_sclk = r_sclk;
    assign o_rise = i_en && (r_cnt == RISE_AT);
    assign o_fall = i_en && (r_cnt == FALL_AT);

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - single-command SPI master: 7-bit address, R/W bit, 8-bit data
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int SCLK_HALF  = DEF_SCLK_HALF,
    parameter int TURNAROUND = DEF_TURNAROUND,
    parameter int CS_IDLE    = DEF_CS_IDLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_rw,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [DATA_BITS-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 sclk_pin,
    output logic                 cs_pin,
    output logic                 mosi_pin,
    input  logic                 miso_pin
);

    localparam logic [15:0] ADDR_LAST = 16'(ADDR_BITS - 1);
    localparam logic [15:0] DATA_LAST = 16'(DATA_BITS - 1);
    localparam logic [15:0] TURN_LAST = 16'(TURNAROUND - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_IDLE * 2 * SCLK_HALF - 1);

    spi_state_t           r_state;
    spi_state_t           w_state_nxt;
    logic [15:0]          r_bitcnt;
    logic                 r_rw;
    logic [TX_BITS-1:0]   r_tx;
    logic [DATA_BITS-1:0] r_rx;
    logic [DATA_BITS-1:0] r_rdata;
    logic                 r_rsp_valid;
    logic                 r_cs;
    logic                 r_mosi;

    logic w_clk_en;
    logic w_sclk;
    logic w_rise;
    logic w_fall;
    logic w_accept;
    logic w_enter_gap;

    assign w_clk_en = (r_state == ST_ADDR) || (r_state == ST_RW) || (r_state == ST_WDATA) ||
                      (r_state == ST_TURN) || (r_state == ST_RDATA);

    spi_clkgen #(
        .SCLK_HALF(SCLK_HALF)
    ) u_clkgen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_clk_en),
        .o_sclk (w_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // State advances only on bit-period ends, except GAP which counts raw clk cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_enter_gap = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = ST_ADDR;
                    w_accept    = 1'b1;
                end
            end
            ST_ADDR: begin
                if (w_fall && r_bitcnt == ADDR_LAST) begin
                    w_state_nxt = ST_RW;
                end
            end
            ST_RW: begin
                if (w_fall) begin
                    if (r_rw != RW_READ) begin
                        w_state_nxt = ST_WDATA;
                    end else if (TURNAROUND == 0) begin
                        w_state_nxt = ST_RDATA;
                    end else begin
                        w_state_nxt = ST_TURN;
                    end
                end
            end
            ST_WDATA, ST_RDATA: begin
                if (w_fall && r_bitcnt == DATA_LAST) begin
                    w_state_nxt = ST_GAP;
                    w_enter_gap = 1'b1;
                end
            end
            ST_TURN: begin
                if (w_fall && r_bitcnt == TURN_LAST) begin
                    w_state_nxt = ST_RDATA;
                end
            end
            ST_GAP: begin
                if (r_bitcnt >= GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bitcnt    <= '0;
            r_rw        <= 1'b0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_cs        <= 1'b1;
            r_mosi      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;

            if (w_state_nxt != r_state) begin
                r_bitcnt <= '0;
            end else if (r_state == ST_GAP || w_fall) begin
                r_bitcnt <= r_bitcnt + 16'd1;
            end

            // Read commands load all-ones behind the R/W bit so mosi idles high afterwards.
            if (w_accept) begin
                r_rw   <= cmd_rw;
                r_tx   <= {cmd_addr, cmd_rw, (cmd_rw == RW_READ) ? {DATA_BITS{1'b1}} : cmd_wdata};
                r_cs   <= 1'b0;
                r_mosi <= cmd_addr[ADDR_BITS-1];
            end else if (w_enter_gap) begin
                r_cs   <= 1'b1;
                r_mosi <= 1'b0;
                if (r_state == ST_RDATA) begin
                    r_rdata     <= r_rx;
                    r_rsp_valid <= 1'b1;
                end
            end else if (w_fall) begin
                r_tx   <= {r_tx[TX_BITS-2:0], 1'b1};
                r_mosi <= r_tx[TX_BITS-2];
            end

            if (w_rise && r_state == ST_RDATA) begin
                r_rx <= {r_rx[DATA_BITS-2:0], miso_pin};
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = !cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign sclk_pin  = w_sclk;
    assign cs_pin    = r_cs;
    assign mosi_pin  = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed scoreboard bench with an SPI slave memory model
module tb_spi_master_ctrl;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       miso_pin = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int rsp_seen = 0;

    logic [7:0]  mem[128];
    int          s_cnt = 0;
    logic [23:0] s_word = '0;
    logic [6:0]  s_addr = '0;
    logic        s_rw = 1'b0;
    int          s_last_cnt = 0;
    logic [23:0] s_last_word = '0;

    int cs_lo_run = 0;
    int cs_hi_run = 0;
    int last_cs_lo = 0;
    int last_cs_hi = 0;

    spi_master_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .sclk_pin  (sclk_pin),
        .cs_pin    (cs_pin),
        .mosi_pin  (mosi_pin),
        .miso_pin  (miso_pin)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave: records mosi at sclk rises, serves read data from mem after the turnaround.
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    end

    always @(negedge cs_pin) begin
        s_cnt  = 0;
        s_word = '0;
        s_rw   = 1'b0;
    end

    always @(posedge sclk_pin) begin
        if (cs_pin === 1'b0) begin
            if (s_cnt < 24) s_word = {s_word[22:0], mosi_pin};
            s_cnt++;
            if (s_cnt == 8) begin
                s_addr = s_word[7:1];
                s_rw   = s_word[0];
            end
        end
    end

    always @(negedge sclk_pin) begin
        if (cs_pin === 1'b0 && s_rw && s_cnt >= 13 && s_cnt <= 20) begin
            int b;
            b = 20 - s_cnt;
            miso_pin = mem[s_addr][b];
        end else begin
            miso_pin = 1'b0;
        end
    end

    always @(posedge cs_pin) begin
        s_last_cnt  = s_cnt;
        s_last_word = s_word;
        if (s_cnt == 16 && s_word[8] == 1'b0) mem[s_word[15:9]] = s_word[7:0];
    end

    always @(negedge clk) begin
        if (cs_pin === 1'b0) begin
            if (cs_hi_run != 0) begin
                last_cs_hi = cs_hi_run;
                cs_hi_run  = 0;
            end
            cs_lo_run++;
        end else begin
            if (cs_lo_run != 0) begin
                last_cs_lo = cs_lo_run;
                cs_lo_run  = 0;
            end
            cs_hi_run++;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            rsp_seen++;
            check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 1000), 32'd1);
    endtask

    task automatic do_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                          input bit expect_rsp, input logic [7:0] exp_data);
        @(negedge clk);
        wait_idle();
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(posedge clk);
        if (expect_rsp) exp_q.push_back(exp_data);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_rw    = ~rw;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        check("cs_low_after_accept", 32'(cs_pin), 32'd0);
        check("first_mosi_bit", 32'(mosi_pin), 32'(addr[6]));
        check("sclk_low_bit_start", 32'(sclk_pin), 32'd0);
        check("ready_low_in_txn", 32'(cmd_ready), 32'd0);
        check("busy_high_in_txn", 32'(busy), 32'd1);
        repeat (H) @(negedge clk);
        check("sclk_high_half", 32'(sclk_pin), 32'd1);
        check("mosi_stable_bit0", 32'(mosi_pin), 32'(addr[6]));
    endtask

    initial begin
        int n;
        int seen0;

        // Reset with cmd_valid asserted: nothing must be accepted.
        cmd_valid = 1'b1;
        cmd_addr  = 7'h5A;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_cs", 32'(cs_pin), 32'd1);
        check("rst_sclk", 32'(sclk_pin), 32'd0);
        check("rst_mosi", 32'(mosi_pin), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_cs", 32'(cs_pin), 32'd1);

        // Write 0x5A <- 0xDB
        seen0 = rsp_seen;
        do_cmd(1'b0, 7'h5A, 8'hDB, 1'b0, 8'h00);
        wait_idle();
        check("wr_bits", 32'(s_last_word), 32'({7'h5A, 1'b0, 8'hDB}));
        check("wr_bitcount", 32'(s_last_cnt), 32'd16);
        check("wr_cs_low", 32'(last_cs_lo), 32'd128);
        check("wr_no_rsp", 32'(rsp_seen), 32'(seen0));

        // Read 0x5A -> 0xDB
        seen0 = rsp_seen;
        do_cmd(1'b1, 7'h5A, 8'h00, 1'b1, 8'hDB);
        wait_idle();
        check("rd_bits", 32'(s_last_word), 32'({7'h5A, 1'b1, 13'h1FFF}));
        check("rd_bitcount", 32'(s_last_cnt), 32'd21);
        check("rd_cs_low", 32'(last_cs_lo), 32'd168);
        check("rd_one_rsp", 32'(rsp_seen), 32'(seen0 + 1));
        check("rd_hold", 32'(rsp_rdata), 32'hDB);

        // Bit-order round trip 0x16 <- 0x55
        do_cmd(1'b0, 7'h16, 8'h55, 1'b0, 8'h00);
        wait_idle();
        check("wr2_bits", 32'(s_last_word), 32'({7'h16, 1'b0, 8'h55}));
        do_cmd(1'b1, 7'h16, 8'h00, 1'b1, 8'h55);
        wait_idle();
        seen0 = rsp_seen;
        do_cmd(1'b0, 7'h01, 8'hF0, 1'b0, 8'h00);
        wait_idle();
        check("rdata_held_over_write", 32'(rsp_rdata), 32'h55);
        check("write_no_pulse", 32'(rsp_seen), 32'(seen0));

        // Back-to-back: cmd_valid held across a write and a following read
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 7'h2A;
        cmd_wdata = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        cmd_rw    = 1'b1;
        cmd_wdata = 8'h00;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("b2b_ready_low_cycles", 32'(n), 32'd144);
        @(posedge clk);
        exp_q.push_back(8'h3C);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_cs_high_gap", 32'(last_cs_hi), 32'd17);
        check("b2b_first_bits", 32'(s_last_word), 32'({7'h2A, 1'b0, 8'h3C}));
        wait_idle();
        check("b2b_read_back", 32'(rsp_rdata), 32'h3C);

        // Reset after the 10th bit of a read
        seen0 = rsp_seen;
        do_cmd(1'b1, 7'h5A, 8'h00, 1'b0, 8'h00);
        n = 0;
        while (s_cnt < 10 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_bit_wait", 32'(n < 1000), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_cs", 32'(cs_pin), 32'd1);
        check("abort_sclk", 32'(sclk_pin), 32'd0);
        check("abort_mosi", 32'(mosi_pin), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_seen), 32'(seen0));
        check("abort_rdata_cleared", 32'(rsp_rdata), 32'd0);
        check("abort_cs_stays_high", 32'(cs_lo_run), 32'd0);

        do_cmd(1'b1, 7'h16, 8'h00, 1'b1, 8'h55);
        wait_idle();
        check("recover_read", 32'(rsp_rdata), 32'h55);
        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
